banked_addr_decoder: RTL and testbench

BANKED_ADDR_DECODER -- requirements
Module: banked_addr_decoder

---
 rtl/banked_addr_decoder_if.sv | 39 +++
 rtl/banked_addr_decoder.sv | 189 ++++++++++++++++++
 tb/tb_banked_addr_decoder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_addr_decoder_if.sv
// banked_addr_decoder_if
// Purpose : bundles the CPU-side bus, I/O port, board option and ROM
//           controller handshake used by banked_addr_decoder.
// Signals : A/mrq            CPU memory request (address + strobe)
//           io_wr/io_rd      I/O strobes, io_addr/io_din in, io_dout out
//           alt_map          board option for the 0x8xxxx page
//           bank_mask        per-bit bank-register vs address select
//           rom_addr/region  registered decode result
//           rom_req/rom_ack  ROM controller handshake
//           ready            one-cycle end-of-access pulse
// Modports: master = CPU / environment side, slave = decoder side.
interface banked_addr_decoder_if #(
  parameter int BANK_W = 4
);
  logic [19:0]          A;
  logic                 mrq;
  logic                 io_wr;
  logic                 io_rd;
  logic [7:0]           io_addr;
  logic [7:0]           io_din;
  logic [7:0]           io_dout;
  logic                 alt_map;
  logic [BANK_W-1:0]    bank_mask;
  logic [16+BANK_W-1:0] rom_addr;
  logic [6:0]           region;
  logic                 rom_req;
  logic                 rom_ack;
  logic                 ready;

  modport master (
    output A, mrq, io_wr, io_rd, io_addr, io_din, alt_map, bank_mask, rom_ack,
    input  io_dout, rom_addr, region, rom_req, ready
  );

  modport slave (
    input  A, mrq, io_wr, io_rd, io_addr, io_din, alt_map, bank_mask, rom_ack,
    output io_dout, rom_addr, region, rom_req, ready
  );
endinterface

// File: rtl/banked_addr_decoder.sv
// banked_addr_decoder
// Purpose : decodes a 20-bit CPU address into one of seven regions, translates
//           ROM accesses (including NUM_BANKS banked 64 KiB windows), and paces
//           the access with a ROM handshake or a fixed wait count.
// Ports   : clk    system clock, rising edge
//           reset  synchronous, active-high
//           bus    banked_addr_decoder_if.slave (see interface file)
// Options : define BANK_READBACK_EN to make bank registers readable on io_dout;
//           otherwise io_dout is tied to zero.
//
// state    | meaning
// IDLE     | waiting for mrq, latches A
// DECODE   | registers region/rom_addr, picks ROM or wait path
// ROM_WAIT | rom_req held until rom_ack sampled
// WAIT     | down-counter from OTHER_WAIT to zero
// DONE     | ready pulse, back to IDLE
module banked_addr_decoder #(
  parameter int         NUM_BANKS  = 2,
  parameter int         BANK_W     = 4,
  parameter logic [3:0] BANK_BASE  = 4'hA,
  parameter logic [7:0] BANK_PORT  = 8'h20,
  parameter int         OTHER_WAIT = 1
) (
  input logic                  clk,
  input logic                  reset,
  banked_addr_decoder_if.slave bus
);
  localparam int RA_W = 16 + BANK_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_ROM_WAIT = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        r_state;
  logic [19:0]       r_addr;
  logic [BANK_W-1:0] r_bank [NUM_BANKS];
  logic [6:0]        r_region;
  logic [RA_W-1:0]   r_rom_addr;
  logic              r_rom_req;
  logic              r_ready;
  logic [2:0]        r_cnt;

  logic              w_win_hit;
  logic [BANK_W-1:0] w_win_bank;
  logic [BANK_W-1:0] w_eff_bank;
  logic [6:0]        w_region;
  logic [RA_W-1:0]   w_rom_addr;

  always_comb begin
    w_win_hit  = 1'b0;
    w_win_bank = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (r_addr[19:16] == BANK_BASE + 4'(k)) begin
        w_win_hit  = 1'b1;
        w_win_bank = r_bank[k];
      end
    end
  end

  assign w_eff_bank = (w_win_bank & bus.bank_mask) |
                      (BANK_W'(r_addr[19:16]) & ~bus.bank_mask);

  // One-hot region {video, sprite, buffer, eeprom, pf_vram, ram, rom}.
  // Holes in the F page leave region at zero and take the wait path.
  always_comb begin
    w_region   = 7'h00;
    w_rom_addr = '0;
    case (r_addr[19:16])
      4'hC: begin
        w_region   = 7'h01;
        w_rom_addr = RA_W'(r_addr[15:0]);
      end
      4'hD: w_region = 7'h04;
      4'hE: w_region = 7'h02;
      4'hF: begin
        if (r_addr[15:14] == 2'b00)          w_region = 7'h08;
        else if (r_addr[15:12] == 4'h8)      w_region = 7'h10;
        else if (r_addr[15:4] == 12'h900)    w_region = 7'h20;
        else if (r_addr[15:1] == 15'h4C00)   w_region = 7'h40;
        else if (r_addr[15:4] == 12'hFFF) begin
          // reset/vector page maps to the top of ROM
          w_region   = 7'h01;
          w_rom_addr = {{(RA_W-4){1'b1}}, r_addr[3:0]};
        end
      end
      default: begin
        if (bus.alt_map && (r_addr[19:16] == 4'h8)) begin
          w_region = 7'h04;
        end else if (w_win_hit) begin
          w_region   = 7'h01;
          w_rom_addr = {w_eff_bank, r_addr[15:0]};
        end else begin
          w_region   = 7'h01;
          w_rom_addr = RA_W'(r_addr);
        end
      end
    endcase
  end

  // Bank registers update in every state; a write landing on the DECODE edge
  // is not seen by that decode because both sample the same old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_region   <= '0;
      r_rom_addr <= '0;
      r_rom_req  <= 1'b0;
      r_ready    <= 1'b0;
      r_cnt      <= '0;
      for (int k = 0; k < NUM_BANKS; k++) r_bank[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (bus.io_wr && (bus.io_addr == BANK_PORT + 8'(k)))
          r_bank[k] <= bus.io_din[BANK_W-1:0];
      end
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.mrq) begin
            r_addr  <= bus.A;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_region   <= w_region;
          r_rom_addr <= w_rom_addr;
          if (w_region[0]) begin
            r_rom_req <= 1'b1;
            r_state   <= S_ROM_WAIT;
          end else begin
            r_cnt   <= 3'(OTHER_WAIT);
            r_state <= S_WAIT;
          end
        end
        S_ROM_WAIT: begin
          if (bus.rom_ack) begin
            r_rom_req <= 1'b0;
            r_ready   <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.region   = r_region;
  assign bus.rom_addr = r_rom_addr;
  assign bus.rom_req  = r_rom_req;
  assign bus.ready    = r_ready;

`ifdef BANK_READBACK_EN
  logic [7:0]        r_io_dout;
  logic              w_rd_hit;
  logic [BANK_W-1:0] w_rd_val;

  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_val = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bus.io_addr == BANK_PORT + 8'(k)) begin
        w_rd_hit = 1'b1;
        w_rd_val = r_bank[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_io_dout <= 8'h00;
    else       r_io_dout <= (bus.io_rd && w_rd_hit) ? 8'(w_rd_val) : 8'h00;
  end

  assign bus.io_dout = r_io_dout;
`else
  assign bus.io_dout = 8'h00;
`endif
endmodule

// File: tb/tb_banked_addr_decoder.sv
module tb_banked_addr_decoder;
  localparam int NB   = 2;
  localparam int BW   = 4;
  localparam int RA_W = 16 + BW;
  localparam int OW   = 1;

  logic clk = 1'b0;
  logic reset;

  banked_addr_decoder_if #(.BANK_W(BW)) bus ();

  banked_addr_decoder #(
    .NUM_BANKS (NB),
    .BANK_W    (BW),
    .BANK_BASE (4'hA),
    .BANK_PORT (8'h20),
    .OTHER_WAIT(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: expected outputs, with a switch cycle for region/rom_addr.
  int              exp_ready_cyc = -10;
  int              req_from = 1;
  int              req_to = 0;
  int              sw_cyc = 0;
  logic [6:0]      cur_rg = '0, nxt_rg = '0;
  logic [RA_W-1:0] cur_ra = '0, nxt_ra = '0;
  bit              cur_rac = 1'b1, nxt_rac = 1'b1;
  logic [7:0]      exp_dout = '0;
  logic [BW-1:0]   m_bank [NB];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Address map from plain address ranges.
  function automatic void model(input logic [19:0] a, input logic alt,
                                input logic [BW-1:0] mask,
                                output logic [6:0] rg, output logic [RA_W-1:0] ra);
    int unsigned x;
    int unsigned page;
    int unsigned off;
    logic [BW-1:0] eff;
    x    = a;
    page = x / 65536;
    off  = x % 65536;
    rg   = 7'd0;
    ra   = '0;
    if (page == 12) begin
      rg = 7'd1; ra = RA_W'(off);
    end else if (page == 13) rg = 7'd4;
    else if (page == 14) rg = 7'd2;
    else if (x >= 'hFFFF0) begin
      rg = 7'd1; ra = RA_W'((1 << RA_W) - 16 + (x % 16));
    end else if (x >= 'hF0000 && x <= 'hF3FFF) rg = 7'd8;
    else if (x >= 'hF8000 && x <= 'hF8FFF) rg = 7'd16;
    else if (x >= 'hF9000 && x <= 'hF900F) rg = 7'd32;
    else if (x == 'hF9800 || x == 'hF9801) rg = 7'd64;
    else if (page == 15) rg = 7'd0;
    else if (alt && page == 8) rg = 7'd4;
    else if (page >= 10 && page < 10 + NB) begin
      eff = (m_bank[page - 10] & mask) | (BW'(page) & ~mask);
      rg  = 7'd1;
      ra  = {eff, 16'(off)};
    end else begin
      rg = 7'd1; ra = RA_W'(x);
    end
  endfunction

  function automatic void mwrite(input logic [7:0] wa, input logic [7:0] wd);
    if (wa >= 8'h20 && wa < 8'h20 + NB) m_bank[wa - 8'h20] = wd[BW-1:0];
  endfunction

  // Single compare process: every cycle after reset release.
  always @(negedge clk) begin
    logic [6:0]      rg;
    logic [RA_W-1:0] ra;
    bit              rac;
    if (chk_en) begin
      if (cyc >= sw_cyc) begin rg = nxt_rg; ra = nxt_ra; rac = nxt_rac; end
      else begin rg = cur_rg; ra = cur_ra; rac = cur_rac; end
      chk("ready", 32'(bus.ready), 32'(cyc == exp_ready_cyc));
      chk("rom_req", 32'(bus.rom_req), 32'(cyc >= req_from && cyc <= req_to));
      chk("region", 32'(bus.region), 32'(rg));
      if (rac) chk("rom_addr", 32'(bus.rom_addr), 32'(ra));
      chk("io_dout", 32'(bus.io_dout), 32'(exp_dout));
    end
  end

  task automatic io_write(input logic [7:0] wa, input logic [7:0] wd);
    @(posedge clk); #1;
    bus.io_wr = 1'b1; bus.io_addr = wa; bus.io_din = wd;
    mwrite(wa, wd);
    @(posedge clk); #1;
    bus.io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] pa);
    logic [7:0] val;
    val = 8'h00;
`ifdef BANK_READBACK_EN
    if (pa >= 8'h20 && pa < 8'h20 + NB) val = 8'(m_bank[pa - 8'h20]);
`endif
    @(posedge clk); #1;
    bus.io_rd = 1'b1; bus.io_addr = pa;
    @(posedge clk); #1;
    bus.io_rd = 1'b0;
    exp_dout = val;
    @(posedge clk); #1;
    exp_dout = 8'h00;
  endtask

  // ROM: ack after ack_dly cycles of rom_req; ready the cycle after the ack.
  // Non-ROM: ready 3+OW cycles after mrq; a stray mrq and rom_ack are driven
  // during the wait and must be ignored.
  task automatic access(input logic [19:0] a, input int ack_dly,
                        input bit do_wr = 1'b0, input logic [7:0] wa = 8'h00,
                        input logic [7:0] wd = 8'h00);
    logic [6:0]      rg;
    logic [RA_W-1:0] ra;
    int              t0;
    @(posedge clk); #1;
    t0 = cyc;
    model(a, bus.alt_map, bus.bank_mask, rg, ra);
    cur_rg = nxt_rg; cur_ra = nxt_ra; cur_rac = nxt_rac;
    nxt_rg = rg; nxt_ra = ra; nxt_rac = rg[0]; sw_cyc = t0 + 2;
    bus.A = a; bus.mrq = 1'b1;
    @(posedge clk); #1;
    bus.mrq = 1'b0; bus.A = 20'h00000;
    if (do_wr) begin
      bus.io_wr = 1'b1; bus.io_addr = wa; bus.io_din = wd;
      mwrite(wa, wd);
    end
    @(posedge clk); #1;
    bus.io_wr = 1'b0;
    if (rg[0]) begin
      req_from = t0 + 2; req_to = 1 << 30;
      repeat (ack_dly) begin @(posedge clk); #1; end
      bus.rom_ack = 1'b1; req_to = cyc; exp_ready_cyc = cyc + 1;
      @(posedge clk); #1;
      bus.rom_ack = 1'b0;
    end else begin
      exp_ready_cyc = t0 + 3 + OW;
      bus.mrq = 1'b1; bus.A = 20'hC0000; bus.rom_ack = 1'b1;
      @(posedge clk); #1;
      bus.mrq = 1'b0;
    end
    while (cyc <= exp_ready_cyc) begin @(posedge clk); #1; end
    bus.rom_ack = 1'b0;
  endtask

  task automatic reset_mid_rom(input logic [19:0] a);
    logic [6:0]      rg;
    logic [RA_W-1:0] ra;
    int              t0;
    @(posedge clk); #1;
    t0 = cyc;
    model(a, bus.alt_map, bus.bank_mask, rg, ra);
    cur_rg = nxt_rg; cur_ra = nxt_ra; cur_rac = nxt_rac;
    nxt_rg = rg; nxt_ra = ra; nxt_rac = 1'b1; sw_cyc = t0 + 2;
    bus.A = a; bus.mrq = 1'b1;
    req_from = t0 + 2; req_to = 1 << 30;
    @(posedge clk); #1;
    bus.mrq = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    req_to = cyc;
    cur_rg = nxt_rg; cur_ra = nxt_ra; cur_rac = nxt_rac;
    nxt_rg = 7'd0; nxt_ra = '0; nxt_rac = 1'b1; sw_cyc = cyc + 1;
    for (int k = 0; k < NB; k++) m_bank[k] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int k = 0; k < NB; k++) m_bank[k] = '0;
    reset = 1'b1;
    bus.A = '0; bus.mrq = 1'b0; bus.io_wr = 1'b0; bus.io_rd = 1'b0;
    bus.io_addr = '0; bus.io_din = '0; bus.alt_map = 1'b0;
    bus.bank_mask = '0; bus.rom_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_region", 32'(bus.region), 32'h00);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h00000);
    chk("rst_rom_req", 32'(bus.rom_req), 32'h0);
    chk("rst_ready", 32'(bus.ready), 32'h0);

    access(20'hC1234, 1);
    chk("lit_C1234_region", 32'(bus.region), 32'h01);
    chk("lit_C1234_rom_addr", 32'(bus.rom_addr), 32'h01234);
    access(20'hC0000, 0);

    io_write(8'h20, 8'h07);
    bus.bank_mask = 4'hF;
    access(20'hA5678, 0);
    chk("lit_bank_mask_F", 32'(bus.rom_addr), 32'h75678);
    bus.bank_mask = 4'h0;
    access(20'hA5678, 0);
    chk("lit_bank_mask_0", 32'(bus.rom_addr), 32'hA5678);
    io_write(8'h21, 8'h03);
    bus.bank_mask = 4'b1010;
    access(20'hB1234, 0);
    chk("lit_bank_mix", 32'(bus.rom_addr), 32'h31234);

    access(20'hF9802, 0);
    chk("lit_F9802_region", 32'(bus.region), 32'h00);
    access(20'hF9801, 0);
    chk("lit_F9801_region", 32'(bus.region), 32'h40);
    access(20'hF9800, 0);
    access(20'hF900F, 0);
    chk("lit_F900F_region", 32'(bus.region), 32'h20);
    access(20'hF9010, 0);
    access(20'hF8000, 0);
    access(20'hF3FFF, 0);
    chk("lit_F3FFF_region", 32'(bus.region), 32'h08);
    access(20'hF4000, 0);
    access(20'hFFFF5, 0);
    chk("lit_FFFF5_rom_addr", 32'(bus.rom_addr), 32'hFFFF5);
    access(20'hFFFEF, 0);
    access(20'hD0001, 0);
    access(20'hE8000, 0);
    chk("lit_E8000_region", 32'(bus.region), 32'h02);
    access(20'h12345, 2);
    access(20'h9ABCD, 0);

    bus.alt_map = 1'b1;
    access(20'h8ABCD, 0);
    chk("lit_alt1_region", 32'(bus.region), 32'h04);
    bus.alt_map = 1'b0;
    access(20'h8ABCD, 0);
    chk("lit_alt0_region", 32'(bus.region), 32'h01);
    chk("lit_alt0_rom_addr", 32'(bus.rom_addr), 32'h8ABCD);

    bus.bank_mask = 4'hF;
    access(20'hA0001, 0, 1'b1, 8'h20, 8'h09);
    chk("lit_wr_during_decode", 32'(bus.rom_addr), 32'h70001);
    access(20'hA0001, 3);
    chk("lit_after_write", 32'(bus.rom_addr), 32'h90001);
    io_write(8'h22, 8'h0F);
    access(20'hB0000, 0);
    chk("lit_out_of_range_wr", 32'(bus.rom_addr), 32'h30000);

    io_read(8'h21);
    io_read(8'h20);
    io_read(8'h22);

    reset_mid_rom(20'hC0010);
    chk("lit_abort_rom_req", 32'(bus.rom_req), 32'h0);
    chk("lit_abort_region", 32'(bus.region), 32'h00);
    access(20'hA5678, 0);
    chk("lit_bank_cleared", 32'(bus.rom_addr), 32'h05678);
    io_read(8'h21);

    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
